// File: rtl/apb_node_pipe.sv
// ---------------------------------------------------------------------------
// apb_node_pipe
// Registered APB 1-to-N demux node. One upstream APB slave port is routed
// to one of NB_MASTER downstream master ports. Routing uses a runtime
// inclusive start/end address map, and on overlap the lowest port wins.
// Every output comes straight from a flop. An address that hits no region
// gets an immediate error response. An access that stalls too long is
// aborted with an error response.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   psel_i .. pwdata_i            upstream request (slave side)
//   prdata_o/pready_o/pslverr_o   upstream response, valid only in RESP
//   psel_o/penable_o              per-port select/enable, one-hot on idx
//   pwrite_o/paddr_o/pwdata_o     captured request, shared by all ports
//   prdata_i/pready_i/pslverr_i   per-port responses
//   start_addr_i/end_addr_i       per-port region, inclusive bounds
//   err_decode_o/err_timeout_o    one-cycle pulses, aligned with RESP
// ---------------------------------------------------------------------------
module apb_node_pipe #(
    parameter int unsigned                NB_MASTER      = 9,
    parameter int unsigned                APB_DATA_WIDTH = 32,
    parameter int unsigned                APB_ADDR_WIDTH = 32,
    parameter int unsigned                TIMEOUT_CYCLES = 256,
    parameter logic [APB_DATA_WIDTH-1:0]  ERR_RDATA      = APB_DATA_WIDTH'(32'hDEADBEEF)
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        psel_i,
    input  logic                                        penable_i,
    input  logic                                        pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0]                   paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]                   pwdata_i,
    output logic [APB_DATA_WIDTH-1:0]                   prdata_o,
    output logic                                        pready_o,
    output logic                                        pslverr_o,
    output logic [NB_MASTER-1:0]                        psel_o,
    output logic [NB_MASTER-1:0]                        penable_o,
    output logic [NB_MASTER-1:0]                        pwrite_o,
    output logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]    paddr_o,
    output logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0]    pwdata_o,
    input  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0]    prdata_i,
    input  logic [NB_MASTER-1:0]                        pready_i,
    input  logic [NB_MASTER-1:0]                        pslverr_i,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]    start_addr_i,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]    end_addr_i,
    output logic                                        err_decode_o,
    output logic                                        err_timeout_o
);

    localparam int unsigned IDX_W = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [APB_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [APB_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                        pwrite_q, pwrite_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NB_MASTER-1:0]        psel_q, psel_d;
    logic [NB_MASTER-1:0]        penable_q, penable_d;
    logic                        pready_q, pready_d;
    logic [APB_DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                        pslverr_q, pslverr_d;
    logic                        err_dec_q, err_dec_d;
    logic                        err_to_q, err_to_d;

    logic                        hit_any;
    logic [IDX_W-1:0]            hit_idx;

    // Address decode. The loop runs from the highest port down, so on overlap
    // the lowest matching port is the one left in hit_idx.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int k = int'(NB_MASTER) - 1; k >= 0; k--) begin
            if (paddr_i >= start_addr_i[k] && paddr_i <= end_addr_i[k]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end
    end

    // The next-value logic also produces the output flop inputs. Each output
    // is then registered and takes its value in the same cycle as the state
    // it belongs to.
    always_comb begin
        // NOTE: every signal gets a default before the case; a path that skips an assignment would otherwise infer a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        pwrite_d  = pwrite_q;
        cnt_d     = cnt_q;
        psel_d    = '0;
        penable_d = '0;
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        err_dec_d = 1'b0;
        err_to_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (psel_i && !penable_i) begin
                    addr_d   = paddr_i;
                    wdata_d  = pwdata_i;
                    pwrite_d = pwrite_i;
                    idx_d    = hit_idx;
                    if (hit_any) begin
                        state_d         = S_SETUP;
                        psel_d[hit_idx] = 1'b1;
                    end else begin
                        state_d   = S_RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        prdata_d  = pwrite_i ? '0 : ERR_RDATA;
                        err_dec_d = 1'b1;
                    end
                end
            end

            S_SETUP: begin
                state_d          = S_ACCESS;
                psel_d[idx_q]    = 1'b1;
                penable_d[idx_q] = 1'b1;
                cnt_d            = '0;
            end

            S_ACCESS: begin
                // A ready peripheral takes priority over timeout expiry in the same cycle.
                if (pready_i[idx_q]) begin
                    state_d   = S_RESP;
                    pready_d  = 1'b1;
                    pslverr_d = pslverr_i[idx_q];
                    prdata_d  = pwrite_q ? '0 : prdata_i[idx_q];
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                    state_d   = S_RESP;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    prdata_d  = pwrite_q ? '0 : ERR_RDATA;
                    err_to_d  = 1'b1;
                end else begin
                    psel_d[idx_q]    = 1'b1;
                    penable_d[idx_q] = 1'b1;
                    if (TIMEOUT_CYCLES != 0) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so that every flop samples the values from before this clock edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            pwrite_q  <= 1'b0;
            cnt_q     <= '0;
            psel_q    <= '0;
            penable_q <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            err_dec_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            pwrite_q  <= pwrite_d;
            cnt_q     <= cnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            err_dec_q <= err_dec_d;
            err_to_q  <= err_to_d;
        end
    end

    // Address, data and direction are shared by all ports. Only PSEL and
    // PENABLE pick out the target port.
    assign paddr_o       = {NB_MASTER{addr_q}};
    assign pwdata_o      = {NB_MASTER{wdata_q}};
    assign pwrite_o      = {NB_MASTER{pwrite_q}};
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign pready_o      = pready_q;
    assign prdata_o      = prdata_q;
    assign pslverr_o     = pslverr_q;
    assign err_decode_o  = err_dec_q;
    assign err_timeout_o = err_to_q;

endmodule

// File: doc/apb_node_pipe.md
Name: apb_node_pipe

Overview:
Registered APB 1-to-N demux node, the parametrised successor of the combinational APB node. One upstream APB slave port fans out to NB_MASTER downstream master ports using a runtime start/end address map. All downstream outputs are registered, which cuts the upstream-to-peripheral timing path. The block also adds a decode-miss error response and a per-access timeout. It sits between the SoC APB bridge and the peripheral cluster.

Parameters:
NB_MASTER, 9, number of downstream master ports (1..32)
APB_DATA_WIDTH, 32, PWDATA/PRDATA width
APB_ADDR_WIDTH, 32, PADDR width
TIMEOUT_CYCLES, 256, max ACCESS cycles before forced error; 0 disables timeout
ERR_RDATA, 'hDEADBEEF (truncated to APB_DATA_WIDTH), PRDATA returned on miss or timeout

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
psel_i  in  1  upstream PSEL
penable_i  in  1  upstream PENABLE
pwrite_i  in  1  upstream PWRITE
paddr_i  in  APB_ADDR_WIDTH  upstream PADDR
pwdata_i  in  APB_DATA_WIDTH  upstream PWDATA
prdata_o  out  APB_DATA_WIDTH  upstream PRDATA
pready_o  out  1  upstream PREADY
pslverr_o  out  1  upstream PSLVERR
psel_o  out  NB_MASTER  per-port PSEL
penable_o  out  NB_MASTER  per-port PENABLE
pwrite_o  out  NB_MASTER  per-port PWRITE
paddr_o  out  NB_MASTER x APB_ADDR_WIDTH  per-port PADDR
pwdata_o  out  NB_MASTER x APB_DATA_WIDTH  per-port PWDATA
prdata_i  in  NB_MASTER x APB_DATA_WIDTH  per-port PRDATA
pready_i  in  NB_MASTER  per-port PREADY
pslverr_i  in  NB_MASTER  per-port PSLVERR
start_addr_i  in  NB_MASTER x APB_ADDR_WIDTH  region start, inclusive
end_addr_i  in  NB_MASTER x APB_ADDR_WIDTH  region end, inclusive
err_decode_o  out  1  one-cycle pulse on decode miss
err_timeout_o  out  1  one-cycle pulse on timeout

Behaviour:
- Clock and reset: single clock clk_i; rst_ni is asynchronous and active-low.
- Reset: state=IDLE. All outputs are 0, including prdata_o, every psel_o/penable_o, and both error pulses. Address/data/index/timeout-counter registers are cleared.
- Shared downstream buses: paddr_o/pwrite_o/pwdata_o drive the same captured value on every port. Only psel_o[idx] and penable_o[idx] are port-specific.
- Decode: hit[k] = start_addr_i[k] <= paddr_i <= end_addr_i[k], unsigned compare. On multiple hits, the lowest k wins. Decode is evaluated only at capture.
- FSM, IDLE:
  - If psel_i & !penable_i: capture paddr/pwrite/pwdata and the decoded idx.
  - On a hit, go to SETUP.
  - On a miss, go to RESP with err=1 and rdata=ERR_RDATA, and pulse err_decode_o in the RESP cycle.
- FSM, SETUP: psel_o[idx]=1, penable_o=0. Always advance to ACCESS after one cycle. Clear the timeout counter.
- FSM, ACCESS: psel_o[idx]=1, penable_o[idx]=1.
  - If pready_i[idx]: latch prdata_i[idx] and pslverr_i[idx], go to RESP.
  - Otherwise, when TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1: go to RESP with err=1 and rdata=ERR_RDATA, pulse err_timeout_o in the RESP cycle, and drop psel/penable.
  - Otherwise increment the counter.
- FSM, RESP: pready_o=1, prdata_o=latched rdata (forced 0 on writes), pslverr_o=latched err. Exactly one cycle, then IDLE.
- pready_o is 0 in every state except RESP. prdata_o and pslverr_o are 0 outside RESP.
- Latency: for a zero-wait peripheral, upstream sees the access phase extended by 2 wait states (setup T0, pready_o high at T3). Each peripheral wait state adds one cycle. Decode miss: pready_o high at T1.
- Back-to-back: a new upstream setup phase in the cycle after RESP is accepted from IDLE without a bubble.
- Upstream protocol violation (psel_i drops mid-transfer): the downstream transfer still completes and the response is discarded. Upstream inputs are ignored outside IDLE.
- Simultaneous pready_i and timeout expiry in the same cycle: pready_i wins (normal response, no err_timeout_o).
- A late pready_i after a timeout is ignored. Each port's psel_o is already low.
- Reset asserted mid-transfer: all outputs drop to 0 immediately (asynchronous). The next transfer after reset release behaves normally.
- Address map changes take effect at the next capture only.

Test Plan:
- Map port0=0x1A100000..0x1A100FFF, port3=0x1A103000..0x1A103FFF. Zero-wait read of 0x1A103004 with prdata_i[3]=0x12345678 -> psel_o[3]=1 at T1, penable_o[3]=1 at T2, pready_o=1 and prdata_o=0x12345678 at T3; no other psel_o asserted.
- Write 0x1A100010 with data 0xCAFEF00D; port0 holds pready_i low 3 cycles -> pwdata_o=0xCAFEF00D and pwrite_o=1; pready_o rises at T6; prdata_o=0; pslverr_o=0.
- Read 0x20000000 (unmapped) -> pready_o=1, pslverr_o=1, prdata_o=0xDEADBEEF and err_decode_o=1 at T1; no psel_o asserted.
- TIMEOUT_CYCLES=4, port3 never ready -> penable_o[3] high 4 cycles, then RESP with pslverr_o=1, prdata_o=0xDEADBEEF, err_timeout_o pulse; a late pready_i[3] is ignored.
- Overlapping maps, port1 and port2 both cover 0x1000 -> access goes to port1 only. pslverr_i[1]=1 -> pslverr_o=1, err_decode_o=0.
- Assert rst_ni low during ACCESS -> all outputs 0 in the same cycle. After release, a read to port0 completes normally with 2 wait states.
